// File: rtl/junction_phase_sequencer.sv
// Two-road junction phase sequencer with a pedestrian crossing.
// Main road rests on green; side road and pedestrians are served on demand.
// Each phase runs for a fixed number of seconds, timed by a cycle prescaler.
// All LED outputs are active-low. The blue LED is the warning (amber) aspect.
module junction_phase_sequencer #(
  parameter int unsigned CLK_HZ       = 20_000_000,
  parameter int unsigned MIN_GREEN_S  = 3,
  parameter int unsigned SIDE_GREEN_S = 5,
  parameter int unsigned WARN_S       = 2,
  parameter int unsigned ALLRED_S     = 1,
  parameter int unsigned WALK_S       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_req,
  input  logic       ped_req,
  output logic       main_red_n,
  output logic       main_green_n,
  output logic       main_blue_n,
  output logic       side_red_n,
  output logic       side_green_n,
  output logic       side_blue_n,
  output logic       ped_walk_n,
  output logic [2:0] state_o
);

  localparam int unsigned CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] CycLast = CW'(CLK_HZ - 1);

  // LED vector order: {main_red, main_green, main_blue, side_red, side_green, side_blue, walk}
  localparam logic [6:0] LedMainGo   = 7'b1010111;
  localparam logic [6:0] LedMainWarn = 7'b1100111;
  localparam logic [6:0] LedAllRed   = 7'b0110111;
  localparam logic [6:0] LedSideGo   = 7'b0111011;
  localparam logic [6:0] LedSideWarn = 7'b0111101;
  localparam logic [6:0] LedWalk     = 7'b0110110;

  typedef enum logic [2:0] {
    StMainGo   = 3'd0,
    StMainWarn = 3'd1,
    StAllRedA  = 3'd2,
    StSideGo   = 3'd3,
    StSideWarn = 3'd4,
    StAllRedB  = 3'd5,
    StWalk     = 3'd6
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [CW-1:0]   r_cyc;
  logic [7:0]      r_sec;
  logic            r_side_pend;
  logic            r_ped_pend;
  logic [6:0]      r_led;
  logic [6:0]      w_led_next;
  logic [7:0]      w_dur;
  logic            w_sec_tick;
  logic            w_timed_done;
  logic            w_changed;

  assign w_sec_tick   = (r_cyc == CycLast);
  // Timed exit fires on the cycle where sec_cnt would reach the phase duration.
  assign w_timed_done = w_sec_tick && (r_sec == (w_dur - 8'd1));
  assign w_changed    = (w_state_next != r_state);

  // Phase duration lookup for the current state (MAIN_GO is demand-driven).
  always_comb begin
    w_dur = 8'd0;
    case (r_state)
      StMainWarn, StSideWarn: w_dur = 8'(WARN_S);
      StAllRedA, StAllRedB:   w_dur = 8'(ALLRED_S);
      StSideGo:               w_dur = 8'(SIDE_GREEN_S);
      StWalk:                 w_dur = 8'(WALK_S);
      default:                w_dur = 8'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StMainGo;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; an unused code falls back to MAIN_GO.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StMainGo: begin
        if ((r_sec >= 8'(MIN_GREEN_S)) && (r_side_pend || r_ped_pend)) begin
          w_state_next = StMainWarn;
        end
      end
      StMainWarn: if (w_timed_done) w_state_next = StAllRedA;
      StAllRedA: begin
        // Pedestrians take priority over the side road.
        if (w_timed_done) w_state_next = r_ped_pend ? StWalk : StSideGo;
      end
      StSideGo:   if (w_timed_done) w_state_next = StSideWarn;
      StSideWarn: if (w_timed_done) w_state_next = StAllRedB;
      StWalk:     if (w_timed_done) w_state_next = StAllRedB;
      StAllRedB:  if (w_timed_done) w_state_next = StMainGo;
      default:    w_state_next = StMainGo;
    endcase
  end

  // Cycle prescaler and saturating seconds counter; both restart on every phase change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= '0;
      r_sec <= 8'd0;
    end else if (w_changed) begin
      r_cyc <= '0;
      r_sec <= 8'd0;
    end else if (w_sec_tick) begin
      r_cyc <= '0;
      if (r_sec != 8'd255) r_sec <= r_sec + 8'd1;
    end else begin
      r_cyc <= r_cyc + 1'b1;
    end
  end

  // Request latches; a request arriving on the entry cycle stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_side_pend <= 1'b0;
      r_ped_pend  <= 1'b0;
    end else begin
      if (side_req) begin
        r_side_pend <= 1'b1;
      end else if ((w_state_next == StSideGo) && (r_state != StSideGo)) begin
        r_side_pend <= 1'b0;
      end
      if (ped_req) begin
        r_ped_pend <= 1'b1;
      end else if ((w_state_next == StWalk) && (r_state != StWalk)) begin
        r_ped_pend <= 1'b0;
      end
    end
  end

  // Output decode from the next state so LEDs change on the same edge as the state.
  always_comb begin
    w_led_next = LedMainGo;
    case (w_state_next)
      StMainGo:              w_led_next = LedMainGo;
      StMainWarn:            w_led_next = LedMainWarn;
      StAllRedA, StAllRedB:  w_led_next = LedAllRed;
      StSideGo:              w_led_next = LedSideGo;
      StSideWarn:            w_led_next = LedSideWarn;
      StWalk:                w_led_next = LedWalk;
      default:               w_led_next = LedMainGo;
    endcase
  end

  // Registered LED outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= LedMainGo;
    end else begin
      r_led <= w_led_next;
    end
  end

  assign {main_red_n, main_green_n, main_blue_n,
          side_red_n, side_green_n, side_blue_n, ped_walk_n} = r_led;
  assign state_o = r_state;

endmodule

// File: tb/tb_junction_phase_sequencer.sv
// Scoreboard bench for junction_phase_sequencer with CLK_HZ=10.
// Stimulus pushes expected {cycle, state} transitions; a monitor pops one on each
// change of state_o and checks timing, state code and LED pattern.
module tb_junction_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic       main_red_n, main_green_n, main_blue_n;
  logic       side_red_n, side_green_n, side_blue_n, ped_walk_n;
  logic [2:0] state_o;
  logic [6:0] leds;

  junction_phase_sequencer #(
    .CLK_HZ(10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .side_req     (side_req),
    .ped_req      (ped_req),
    .main_red_n   (main_red_n),
    .main_green_n (main_green_n),
    .main_blue_n  (main_blue_n),
    .side_red_n   (side_red_n),
    .side_green_n (side_green_n),
    .side_blue_n  (side_blue_n),
    .ped_walk_n   (ped_walk_n),
    .state_o      (state_o)
  );

  assign leds = {main_red_n, main_green_n, main_blue_n,
                 side_red_n, side_green_n, side_blue_n, ped_walk_n};

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] st;
  } ev_t;

  ev_t        sb[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         tb_cyc = -1;
  logic [2:0] prev_st = 3'd0;

  // Active-low LED pattern expected for a state code, built light by light.
  function automatic logic [6:0] led_of(input logic [2:0] s);
    logic mr, mg, mb, sr, sg, sb_l, pw;
    mr   = (s == 3'd2) || (s == 3'd3) || (s == 3'd4) || (s == 3'd5) || (s == 3'd6);
    mg   = (s == 3'd0);
    mb   = (s == 3'd1);
    sr   = (s == 3'd0) || (s == 3'd1) || (s == 3'd2) || (s == 3'd5) || (s == 3'd6);
    sg   = (s == 3'd3);
    sb_l = (s == 3'd4);
    pw   = (s == 3'd6);
    return ~{mr, mg, mb, sr, sg, sb_l, pw};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, tb_cyc);
    end
  endtask

  task automatic exp_ev(input int c, input logic [2:0] s);
    sb.push_back('{cyc: c, st: s});
  endtask

  // Edge counter: cycle 0 is the first rising edge after rst_n rises.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) tb_cyc = -1;
    else tb_cyc++;
  end

  // Monitor: samples on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_st = 3'd0;
    end else begin
      check("no_conflicting_greens",
            int'(!((!main_green_n && !side_green_n) ||
                   ((!main_green_n || !side_green_n) && !ped_walk_n))), 1);
      check("leds_vs_state", leds, led_of(state_o));
      if (state_o != prev_st) begin
        if (sb.size() == 0) begin
          check("unexpected_change", state_o, prev_st);
        end else begin
          ev_t ev;
          ev = sb.pop_front();
          check("event_cycle", tb_cyc, ev.cyc);
          check("event_state", state_o, ev.st);
          check("event_leds", leds, led_of(ev.st));
        end
        prev_st = state_o;
      end
    end
  end

  // Advance to the falling edge after rising edge c.
  task automatic go_to(input int c);
    while (tb_cyc < c) @(negedge clk);
  endtask

  // Drive requests so they are latched on edges c .. c+len-1.
  task automatic pulse(input bit s, input bit p, input int c, input int len);
    go_to(c - 1);
    side_req = s;
    ped_req  = p;
    go_to(c + len - 1);
    side_req = 1'b0;
    ped_req  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", state_o, 0);
    check("reset_leds", leds, led_of(3'd0));
    sb.delete();
    rst_n = 1'b1;
  endtask

  task automatic end_scn(input string name, input int upto);
    go_to(upto);
    check({name, "_pending_events"}, sb.size(), 0);
    check({name, "_final_state"}, state_o, 0);
    sb.delete();
  endtask

  // Side served once, then a request landing at/after SIDE_GO entry gets it served again.
  // MAIN_GO entered at 140 needs 31 edges before sec_cnt>=3 is seen, hence 171.
  task automatic run_side_twice(input string name, input int hold_from, input int hold_len);
    do_reset();
    exp_ev(30, 3'd1);  exp_ev(50, 3'd2);  exp_ev(60, 3'd3);
    exp_ev(110, 3'd4); exp_ev(130, 3'd5); exp_ev(140, 3'd0);
    exp_ev(171, 3'd1); exp_ev(191, 3'd2); exp_ev(201, 3'd3);
    exp_ev(251, 3'd4); exp_ev(271, 3'd5); exp_ev(281, 3'd0);
    pulse(1'b1, 1'b0, 5, 1);
    pulse(1'b1, 1'b0, hold_from, hold_len);
    end_scn(name, 340);
  endtask

  initial begin
    // Idle past sec_cnt saturation, then a side request must be served immediately.
    do_reset();
    go_to(2568);
    check("idle_state", state_o, 0);
    check("idle_leds", leds, led_of(3'd0));
    exp_ev(2571, 3'd1); exp_ev(2591, 3'd2); exp_ev(2601, 3'd3);
    exp_ev(2651, 3'd4); exp_ev(2671, 3'd5); exp_ev(2681, 3'd0);
    pulse(1'b1, 1'b0, 2570, 1);
    end_scn("idle_sat", 2720);

    // Side request pulse at cycle 5.
    do_reset();
    exp_ev(30, 3'd1);  exp_ev(50, 3'd2);  exp_ev(60, 3'd3);
    exp_ev(110, 3'd4); exp_ev(130, 3'd5); exp_ev(140, 3'd0);
    pulse(1'b1, 1'b0, 5, 1);
    end_scn("side", 200);

    // Pedestrian pulse after minimum green: walk lit 131..170.
    do_reset();
    exp_ev(101, 3'd1); exp_ev(121, 3'd2); exp_ev(131, 3'd6);
    exp_ev(171, 3'd5); exp_ev(181, 3'd0);
    pulse(1'b0, 1'b1, 100, 1);
    end_scn("ped", 250);

    // Both requests together: walk first, then side after the next minimum green.
    do_reset();
    exp_ev(51, 3'd1);  exp_ev(71, 3'd2);  exp_ev(81, 3'd6);
    exp_ev(121, 3'd5); exp_ev(131, 3'd0);
    exp_ev(162, 3'd1); exp_ev(182, 3'd2); exp_ev(192, 3'd3);
    exp_ev(242, 3'd4); exp_ev(262, 3'd5); exp_ev(272, 3'd0);
    pulse(1'b1, 1'b1, 50, 1);
    end_scn("both", 330);

    // Request coinciding with SIDE_GO entry, then a level hold during SIDE_GO.
    run_side_twice("side_coincident", 60, 1);
    run_side_twice("side_held", 70, 21);

    // Async reset mid SIDE_GO with a pedestrian pending: no service afterwards.
    do_reset();
    exp_ev(30, 3'd1); exp_ev(50, 3'd2); exp_ev(60, 3'd3);
    pulse(1'b1, 1'b0, 5, 1);
    pulse(1'b0, 1'b1, 70, 1);
    go_to(80);
    check("pre_reset_state", state_o, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_state", state_o, 0);
    check("async_reset_leds", leds, led_of(3'd0));
    check("async_reset_events_done", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    end_scn("after_reset", 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog: the run must never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
